eu_dispatch_allocator: RTL
==========================

Name: eu_dispatch_allocator

Overview:
Credit-based dispatch allocator between the front-end rename/dispatch stage and the per-EU issue queues.
- Takes a batch of up to NUM_PARALLEL_INSTR_DISPATCHES instructions and assigns each valid lane an exec-unit index, round-robin across EUs.
- Tracks free issue-queue slots per EU as credits, so an issue queue never receives an instruction it cannot hold.
- Drives the dispatch bus (instr, valid, alloc_euidx) broadcast to every EU issue queue.

Parameters:
- NUM_PARALLEL_INSTR_DISPATCHES, 4, lanes per dispatch batch.
- EU_CREDITS, 64, slots per EU issue queue (queues x queue depth, 4 x 16).
- CREDIT_W, $clog2(EU_CREDITS+1), credit counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- batch_instr_i  in  type_iqueue_entry x NUM_PARALLEL_INSTR_DISPATCHES  incoming batch
- batch_lane_valid_i  in  NUM_PARALLEL_INSTR_DISPATCHES  per-lane valid
- batch_valid_i  in  1  batch present
- batch_ready_o  out  1  batch accepted this cycle (comb)
- dispatched_instr_o  out  type_iqueue_entry x NUM_PARALLEL_INSTR_DISPATCHES  registered dispatch bus
- dispatched_instr_valid_o  out  NUM_PARALLEL_INSTR_DISPATCHES  registered lane valid
- dispatched_instr_alloc_euidx_o  out  LOG2_NUM_EXEC_UNITS x NUM_PARALLEL_INSTR_DISPATCHES  registered EU index per lane
- credit_return_i  in  NUM_EXEC_UNITS  one pulse per EU per dequeued instr (ready & valid at EU)
- eu_credits_o  out  CREDIT_W x NUM_EXEC_UNITS  current credit counts (debug/perf)

Behaviour:
- Reset (async, reset_n low):
  - credits[e] = EU_CREDITS; rr_ptr = 0.
  - All dispatched_*_o = 0.
  - Outputs take reset values immediately, no clock required.
- Allocation is combinational from registered credits and rr_ptr.
  - Lanes are processed 0 to N-1; each valid lane takes the first EU at or after the candidate pointer that has tentative credit > 0.
  - That EU's tentative credit is decremented; the candidate pointer becomes EU+1 (mod NUM_EXEC_UNITS).
  - The candidate pointer starts at rr_ptr.
  - Invalid lanes are skipped and keep euidx 0.
- All-or-nothing:
  - batch_ready_o = 1 iff every valid lane found an EU.
  - If any lane fails, batch_ready_o = 0 and no state changes; the front end holds the batch.
- Fire = batch_valid_i & batch_ready_o.
  - On fire, next cycle: dispatched_instr_o = batch_instr_i, dispatched_instr_valid_o = batch_lane_valid_i, euidx = allocation. Latency is 1 cycle.
  - rr_ptr <= final candidate pointer.
- No fire: dispatched_instr_valid_o = 0 next cycle (single-cycle pulse per batch). Data and euidx regs hold their values.
- Empty batch (batch_valid_i = 1, no lane valid): batch_ready_o = 1, fire produces all-zero valids, rr_ptr unchanged.
- Credit update per EU per cycle: credits_next = credits - allocated_on_fire + credit_return_i[e].
  - Returns are not forwarded into the same-cycle allocation.
  - Same-cycle allocate and return are allowed.
- Overflow: a return at credits == EU_CREDITS with no same-cycle allocation saturates at EU_CREDITS and fires an assertion.
  - An allocation never takes a credit below 0, by construction.
- Arithmetic: rr_ptr is LOG2_NUM_EXEC_UNITS wide and wraps naturally. NUM_EXEC_UNITS must be a power of 2.
- Invariant (assertion): sum over e of (EU_CREDITS - credits[e]) equals instructions dispatched minus credits returned.

Decomposition:
- pkg_dtypes supplies:
  - type_iqueue_entry
  - LOG2_NUM_EXEC_UNITS
  - NUM_EXEC_UNITS = 2**LOG2_NUM_EXEC_UNITS; add it to the package if absent.
- Sub-module eu_credit_counter, one instance per EU:
  - Inputs: alloc count (0 to NUM_PARALLEL_INSTR_DISPATCHES), return bit.
  - Output: credit count.
  - Holds the reset value and saturation/assertion logic.
- Round-robin lane assignment is an always_comb loop in the top module.

Test Plan:
Bench config: LOG2_NUM_EXEC_UNITS = 2, EU_CREDITS = 4.
1. Post-reset batch, lanes 1111, rr_ptr 0:
   - ready = 1; next cycle valid = 1111, euidx = {0,1,2,3}.
   - credits = {3,3,3,3}; rr_ptr = 0.
2. Lanes 1010, rr_ptr 0:
   - lane1 -> EU0, lane3 -> EU1; lanes 0 and 2 invalid.
   - rr_ptr = 2; credits {3,3,4,4}.
3. credits {4,0,4,4}, lanes 1111, rr_ptr 0:
   - euidx = {0,2,3,0}; credits {2,0,3,3}; rr_ptr = 1.
4. credits {0,0,1,0}, lanes 0011, rr_ptr 0:
   - ready = 0, held; outputs valid = 0.
   - Pulse credit_return_i[0] -> next cycle ready = 1, lane0 -> EU0, lane1 -> EU2; credits {0,0,0,0}.
5. credits[1] = 1, single lane allocated to EU1 while credit_return_i[1] = 1:
   - credits[1] stays 1.
   - Separately, a return at credits = 4 -> stays 4 and the assertion fires.
6. Assert reset_n low mid-cycle while dispatched_instr_valid_o = 1111:
   - valids drop to 0 asynchronously; credits read 4 and rr_ptr = 0 after release.

Source files
------------

// File: rtl/pkg_dtypes.sv
// Shared datapath types for the dispatch stage.
// Issue-queue entry layout and exec-unit count.
package pkg_dtypes;

  localparam int LOG2_NUM_EXEC_UNITS = 2;
  localparam int NUM_EXEC_UNITS = 2 ** LOG2_NUM_EXEC_UNITS;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  tag;
  } type_iqueue_entry;

endpackage

// File: rtl/eu_credit_counter.sv
// Free-slot credit counter for one exec-unit issue queue.
// Takes up to a batch of allocations and one return per cycle.
module eu_credit_counter #(
  parameter int EU_CREDITS = 64,
  parameter int CNT_W      = 3,
  parameter int CREDIT_W   = $clog2(EU_CREDITS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CNT_W-1:0]    alloc_cnt_i,
  input  logic                return_i,
  output logic [CREDIT_W-1:0] credit_o
);

  localparam int SW = CREDIT_W + 1;
  localparam logic [SW-1:0] FULL = SW'(EU_CREDITS);

  logic [CREDIT_W-1:0] r_credit;
  logic [SW-1:0]       w_sum;

  assign w_sum = SW'(r_credit) + SW'(return_i)
               - SW'(alloc_cnt_i);
  assign credit_o = r_credit;

  // Credit register; a return beyond full saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credit <= CREDIT_W'(EU_CREDITS);
    end else if (w_sum > FULL) begin
      r_credit <= CREDIT_W'(EU_CREDITS);
    end else begin
      r_credit <= w_sum[CREDIT_W-1:0];
    end
  end

`ifndef SYNTHESIS
  // Flag a return that arrives while the queue is already empty.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(return_i && alloc_cnt_i == '0 &&
                r_credit == CREDIT_W'(EU_CREDITS)))
        else $warning("eu_credit_counter: return at full count, saturated");
    end
  end
`endif

endmodule

// File: rtl/eu_dispatch_allocator.sv
// Credit-based round-robin dispatch of a lane batch to exec units.
// Batch is all-or-nothing; dispatch bus is registered, 1-cycle latency.
module eu_dispatch_allocator
  import pkg_dtypes::*;
#(
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter int EU_CREDITS = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                batch_instr_i,
  input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                batch_lane_valid_i,
  input  logic batch_valid_i,
  output logic batch_ready_o,
  output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                dispatched_instr_o,
  output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                dispatched_instr_valid_o,
  output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0]
                dispatched_instr_alloc_euidx_o,
  input  logic [NUM_EXEC_UNITS-1:0] credit_return_i,
  output logic [NUM_EXEC_UNITS-1:0][$clog2(EU_CREDITS+1)-1:0]
                eu_credits_o
);

  localparam int N  = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int E  = NUM_EXEC_UNITS;
  localparam int LW = LOG2_NUM_EXEC_UNITS;
  localparam int CREDIT_W = $clog2(EU_CREDITS + 1);
  localparam int AW = $clog2(N + 1);

  logic [LW-1:0]                r_rr_ptr;
  logic [E-1:0][CREDIT_W-1:0]   w_credits;
  logic [E-1:0][CREDIT_W-1:0]   w_tent;
  logic [E-1:0][AW-1:0]         w_alloc;
  logic [E-1:0][AW-1:0]         w_alloc_fire;
  logic [N-1:0][LW-1:0]         w_euidx;
  logic [LW-1:0]                w_ptr;
  logic [LW-1:0]                w_cand;
  logic [LW-1:0]                w_pick;
  logic                         w_found;
  logic                         w_ok;
  logic                         w_fire;

  // Lane-ordered round-robin search over tentative credits.
  always_comb begin
    w_tent  = w_credits;
    w_ptr   = r_rr_ptr;
    w_ok    = 1'b1;
    w_alloc = '0;
    w_euidx = '0;
    w_cand  = '0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int l = 0; l < N; l++) begin
      if (batch_lane_valid_i[l]) begin
        w_found = 1'b0;
        w_pick  = w_ptr;
        for (int k = 0; k < E; k++) begin
          w_cand = w_ptr + LW'(k);
          if (!w_found && w_tent[w_cand] != '0) begin
            w_found = 1'b1;
            w_pick  = w_cand;
          end
        end
        if (w_found) begin
          w_tent[w_pick]  = w_tent[w_pick] - CREDIT_W'(1);
          w_alloc[w_pick] = w_alloc[w_pick] + AW'(1);
          w_euidx[l]      = w_pick;
          w_ptr           = w_pick + LW'(1);
        end else begin
          w_ok = 1'b0;
        end
      end
    end
  end

  assign batch_ready_o = w_ok;
  assign w_fire = batch_valid_i & w_ok;
  assign eu_credits_o = w_credits;

  for (genvar e = 0; e < E; e++) begin : g_eu
    assign w_alloc_fire[e] = w_fire ? w_alloc[e] : '0;

    eu_credit_counter #(
      .EU_CREDITS (EU_CREDITS),
      .CNT_W      (AW),
      .CREDIT_W   (CREDIT_W)
    ) u_cnt (
      .clk         (clk),
      .reset_n     (reset_n),
      .alloc_cnt_i (w_alloc_fire[e]),
      .return_i    (credit_return_i[e]),
      .credit_o    (w_credits[e])
    );
  end

  // Dispatch bus and round-robin pointer; valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dispatched_instr_o             <= '0;
      dispatched_instr_valid_o       <= '0;
      dispatched_instr_alloc_euidx_o <= '0;
      r_rr_ptr                       <= '0;
    end else begin
      dispatched_instr_valid_o <= w_fire ? batch_lane_valid_i : '0;
      if (w_fire) begin
        dispatched_instr_o             <= batch_instr_i;
        dispatched_instr_alloc_euidx_o <= w_euidx;
        r_rr_ptr                       <= w_ptr;
      end
    end
  end

`ifndef SYNTHESIS
  int   r_outstanding;
  logic r_ovf_seen;
  int   w_used;
  int   w_delta;
  logic w_ovf;

  // Occupancy implied by credits versus dispatch/return traffic.
  always_comb begin
    w_used  = 0;
    w_delta = 0;
    w_ovf   = 1'b0;
    for (int e = 0; e < E; e++) begin
      w_used  = w_used + EU_CREDITS - int'(w_credits[e]);
      w_delta = w_delta - int'(credit_return_i[e]);
      if (credit_return_i[e] && w_alloc_fire[e] == '0 &&
          w_credits[e] == CREDIT_W'(EU_CREDITS))
        w_ovf = 1'b1;
    end
    for (int l = 0; l < N; l++) begin
      if (w_fire)
        w_delta = w_delta + int'(batch_lane_valid_i[l]);
    end
  end

  // Running count of instructions in flight; overflow breaks it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= 0;
      r_ovf_seen    <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + w_delta;
      r_ovf_seen    <= r_ovf_seen | w_ovf;
    end
  end

  // Credits consumed must match instructions still in flight.
  always @(posedge clk) begin
    if (reset_n && !r_ovf_seen) begin
      assert (w_used == r_outstanding)
        else $error("eu_dispatch_allocator: credit invariant broken");
    end
  end
`endif

endmodule
